// File: rtl/reg_status_file_pkg.sv
// reg_status_file_pkg: shared sizing constants for the register status file.
package reg_status_file_pkg;
   localparam int ROB_SIZE_LOG = 4;
   localparam int REG_NUM = 32;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_status_file_if.sv
// reg_status_file_if: issue, commit and operand-query signals of the register status file.
interface reg_status_file_if #(parameter int TAG_W = reg_status_file_pkg::ROB_SIZE_LOG);
   logic rdy;
   logic flush;
   logic issue_valid;
   logic [4:0] issue_rd;
   logic [TAG_W-1:0] issue_robid;
   logic commit_enable;
   logic [4:0] commit_regid;
   logic [31:0] commit_value;
   logic [TAG_W-1:0] commit_robid;
   logic [4:0] rs1_idx;
   logic [4:0] rs2_idx;
   logic rs1_busy;
   logic [TAG_W-1:0] rs1_tag;
   logic [31:0] rs1_val;
   logic rs2_busy;
   logic [TAG_W-1:0] rs2_tag;
   logic [31:0] rs2_val;
   modport master(
      output rdy, flush, issue_valid, issue_rd, issue_robid,
      output commit_enable, commit_regid, commit_value, commit_robid, rs1_idx, rs2_idx,
      input rs1_busy, rs1_tag, rs1_val, rs2_busy, rs2_tag, rs2_val
   );
   modport slave(
      input rdy, flush, issue_valid, issue_rd, issue_robid,
      input commit_enable, commit_regid, commit_value, commit_robid, rs1_idx, rs2_idx,
      output rs1_busy, rs1_tag, rs1_val, rs2_busy, rs2_tag, rs2_val
   );
endinterface

// File: rtl/reg_status_file_read_port.sv
// reg_read_port: combinational operand read; REG_COMMIT_BYPASS_EN forwards a matching commit in the same cycle.
module reg_read_port
   import reg_status_file_pkg::*;
#(
   parameter int TAG_W = ROB_SIZE_LOG,
   parameter int NREG = REG_NUM
) (
   input logic [4:0] idx,
   input logic [NREG-1:0] busy,
   input logic [TAG_W-1:0] tag [NREG],
   input logic [31:0] val [NREG],
   input logic commit_enable,
   input logic [4:0] commit_regid,
   input logic [31:0] commit_value,
   input logic [TAG_W-1:0] commit_robid,
   output logic rs_busy,
   output logic [TAG_W-1:0] rs_tag,
   output logic [31:0] rs_val
);
`ifdef REG_COMMIT_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic hit;
   assign hit = BYP && commit_enable && commit_regid == idx && idx != REG_ZERO &&
                busy[idx] && tag[idx] == commit_robid;
   assign rs_busy = busy[idx] && !hit;
   assign rs_tag = tag[idx];
   assign rs_val = hit ? commit_value : val[idx];
endmodule

// File: rtl/reg_status_file.sv
// reg_status_file: architectural registers with rename busy/tag state; optional REG_COMMIT_BYPASS_EN read bypass.
module reg_status_file
   import reg_status_file_pkg::*;
#(
   parameter int TAG_W = ROB_SIZE_LOG,
   parameter int NREG = REG_NUM
) (
   input logic clk,
   input logic rst,
   reg_status_file_if.slave bus
);
   logic [31:0] val [NREG];
   logic [TAG_W-1:0] tag [NREG];
   logic [NREG-1:0] busy, ren, clr;
   // x0 is excluded from both vectors, so it can never become busy
   always_comb begin
      ren = '0;
      clr = '0;
      for (int i = 1; i < NREG; i++) begin
         ren[i] = bus.issue_valid && !bus.flush && int'(bus.issue_rd) == i;
         clr[i] = bus.flush || (bus.commit_enable && int'(bus.commit_regid) == i &&
                  busy[i] && tag[i] == bus.commit_robid);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
         for (int i = 0; i < NREG; i++) begin
            val[i] <= '0;
            tag[i] <= '0;
         end
      end else if (bus.rdy) begin
         if (bus.commit_enable && bus.commit_regid != REG_ZERO) val[bus.commit_regid] <= bus.commit_value;
         for (int i = 0; i < NREG; i++) begin
            busy[i] <= ren[i] || (busy[i] && !clr[i]);
            if (ren[i]) tag[i] <= bus.issue_robid;
         end
      end
   end
   reg_read_port #(.TAG_W(TAG_W), .NREG(NREG)) u_rs1 (
      .idx(bus.rs1_idx), .busy(busy), .tag(tag), .val(val),
      .commit_enable(bus.commit_enable), .commit_regid(bus.commit_regid),
      .commit_value(bus.commit_value), .commit_robid(bus.commit_robid),
      .rs_busy(bus.rs1_busy), .rs_tag(bus.rs1_tag), .rs_val(bus.rs1_val)
   );
   reg_read_port #(.TAG_W(TAG_W), .NREG(NREG)) u_rs2 (
      .idx(bus.rs2_idx), .busy(busy), .tag(tag), .val(val),
      .commit_enable(bus.commit_enable), .commit_regid(bus.commit_regid),
      .commit_value(bus.commit_value), .commit_robid(bus.commit_robid),
      .rs_busy(bus.rs2_busy), .rs_tag(bus.rs2_tag), .rs_val(bus.rs2_val)
   );
endmodule

// File: tb/tb_reg_status_file.sv
// tb_reg_status_file: vector table, hand sequences and random run against a register-file model.
module tb_reg_status_file;
   logic clk = 1'b0;
   logic rst;
   int checks = 0;
   int failures = 0;
   logic [31:0] m_val [32];
   logic m_busy [32];
   logic [3:0] m_tag [32];

   always #5 clk = ~clk;

   reg_status_file_if bus();
   reg_status_file dut(.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic rdy, fl, iv; logic [4:0] rd; logic [3:0] rob;
      logic ce; logic [4:0] cr; logic [31:0] cv; logic [3:0] crob;
      logic [4:0] r1, r2;
      logic b1; logic [3:0] t1; logic [31:0] v1;
      logic b2; logic [3:0] t2; logic [31:0] v2;
   } vec_t;
   vec_t tbl [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rdy, fl, iv, input logic [4:0] rd, input logic [3:0] rob,
                        input logic ce, input logic [4:0] cr, input logic [31:0] cv,
                        input logic [3:0] crob, input logic [4:0] r1, r2);
      bus.rdy = rdy; bus.flush = fl; bus.issue_valid = iv; bus.issue_rd = rd; bus.issue_robid = rob;
      bus.commit_enable = ce; bus.commit_regid = cr; bus.commit_value = cv; bus.commit_robid = crob;
      bus.rs1_idx = r1; bus.rs2_idx = r2;
   endtask

   // Architectural model: commit first, then flush or rename, so a same-cycle rename wins.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
      end else if (bus.rdy) begin
         if (bus.commit_enable && bus.commit_regid != 0) begin
            m_val[bus.commit_regid] = bus.commit_value;
            if (m_busy[bus.commit_regid] && m_tag[bus.commit_regid] == bus.commit_robid)
               m_busy[bus.commit_regid] = 0;
         end
         if (bus.flush) for (int i = 0; i < 32; i++) m_busy[i] = 0;
         else if (bus.issue_valid && bus.issue_rd != 0) begin
            m_busy[bus.issue_rd] = 1;
            m_tag[bus.issue_rd] = bus.issue_robid;
         end
      end
      @(negedge clk);
   endtask

   task automatic model_read(input logic [4:0] idx, output logic b, output logic [3:0] t, output logic [31:0] v);
      b = m_busy[idx]; t = m_tag[idx]; v = m_val[idx];
`ifdef REG_COMMIT_BYPASS_EN
      if (bus.commit_enable && bus.commit_regid == idx && idx != 0 && b && t == bus.commit_robid) begin
         b = 0;
         v = bus.commit_value;
      end
`endif
   endtask

   initial begin
      logic b;
      logic [3:0] t;
      logic [31:0] v;
      rst = 1'b1;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      tick();
      rst = 1'b0;
      //             rdy fl iv rd rob ce cr cv            crob r1 r2  b1 t1 v1            b2 t2 v2
      tbl.push_back('{1, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 3, 5, 0, 0, 0, 32'h0,        0, 0, 32'h0});
      tbl.push_back('{1, 0, 1, 7, 2, 0, 0, 32'h0,        0, 5, 7, 0, 0, 32'hDEADBEEF, 0, 0, 32'h0});
      tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 7, 5, 1, 2, 32'h0,        0, 0, 32'hDEADBEEF});
      tbl.push_back('{1, 0, 0, 0, 0, 1, 7, 32'h11,       2, 5, 0, 0, 0, 32'hDEADBEEF, 0, 0, 32'h0});
      tbl.push_back('{1, 0, 1, 7, 2, 0, 0, 32'h0,        0, 7, 0, 0, 2, 32'h11,       0, 0, 32'h0});
      tbl.push_back('{1, 0, 1, 7, 5, 0, 0, 32'h0,        0, 7, 0, 1, 2, 32'h11,       0, 0, 32'h0});
      tbl.push_back('{1, 0, 0, 0, 0, 1, 7, 32'h22,       2, 7, 0, 1, 5, 32'h11,       0, 0, 32'h0});
      tbl.push_back('{1, 0, 1, 9, 4, 0, 0, 32'h0,        0, 7, 9, 1, 5, 32'h22,       0, 0, 32'h0});
      tbl.push_back('{1, 0, 1, 9, 6, 1, 9, 32'h99,       4, 7, 0, 1, 5, 32'h22,       0, 0, 32'h0});
      tbl.push_back('{1, 0, 1, 3, 1, 0, 0, 32'h0,        0, 9, 0, 1, 6, 32'h99,       0, 0, 32'h0});
      tbl.push_back('{1, 0, 1, 8, 7, 0, 0, 32'h0,        0, 3, 0, 1, 1, 32'h0,        0, 0, 32'h0});
      tbl.push_back('{1, 0, 1, 12, 8, 0, 0, 32'h0,       0, 8, 0, 1, 7, 32'h0,        0, 0, 32'h0});
      tbl.push_back('{0, 1, 1, 10, 9, 1, 3, 32'h55,      1, 12, 10, 1, 8, 32'h0,      0, 0, 32'h0});
      tbl.push_back('{1, 1, 1, 10, 9, 1, 3, 32'h33,      1, 12, 8, 1, 8, 32'h0,       1, 7, 32'h0});
      tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 3, 10, 0, 1, 32'h33,      0, 0, 32'h0});
      tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 12, 7, 0, 8, 32'h0,       0, 5, 32'h22});
      tbl.push_back('{1, 0, 1, 0, 3, 1, 0, 32'hFFFF,     0, 0, 9, 0, 0, 32'h0,        0, 6, 32'h99});
      tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0});
      foreach (tbl[n]) begin
         drive(tbl[n].rdy, tbl[n].fl, tbl[n].iv, tbl[n].rd, tbl[n].rob, tbl[n].ce, tbl[n].cr,
               tbl[n].cv, tbl[n].crob, tbl[n].r1, tbl[n].r2);
         #1;
         chk($sformatf("row%0d rs1_busy", n), 32'(bus.rs1_busy), 32'(tbl[n].b1));
         chk($sformatf("row%0d rs1_tag", n), 32'(bus.rs1_tag), 32'(tbl[n].t1));
         chk($sformatf("row%0d rs1_val", n), bus.rs1_val, tbl[n].v1);
         chk($sformatf("row%0d rs2_busy", n), 32'(bus.rs2_busy), 32'(tbl[n].b2));
         chk($sformatf("row%0d rs2_tag", n), 32'(bus.rs2_tag), 32'(tbl[n].t2));
         chk($sformatf("row%0d rs2_val", n), bus.rs2_val, tbl[n].v2);
         tick();
      end

      // Reset must win over rdy=0.
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 9);
      tick();
      rst = 1'b0;
      #1;
      chk("rst x7 val", bus.rs1_val, 32'h0);
      chk("rst x7 tag", 32'(bus.rs1_tag), 32'h0);
      chk("rst x9 val", bus.rs2_val, 32'h0);
      chk("rst x9 tag", 32'(bus.rs2_tag), 32'h0);

      // Commit of a busy register read in the same cycle.
      drive(1, 0, 1, 7, 2, 0, 0, 0, 0, 7, 0);
      tick();
      drive(1, 0, 0, 0, 0, 1, 7, 32'h44, 2, 7, 7);
      #1;
`ifdef REG_COMMIT_BYPASS_EN
      chk("byp busy", 32'(bus.rs1_busy), 32'h0);
      chk("byp val", bus.rs2_val, 32'h44);
`else
      chk("byp busy", 32'(bus.rs1_busy), 32'h1);
      chk("byp val", bus.rs2_val, 32'h0);
`endif
      chk("byp tag", 32'(bus.rs1_tag), 32'h2);
      tick();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
      #1;
      chk("post commit busy", 32'(bus.rs1_busy), 32'h0);
      chk("post commit val", bus.rs1_val, 32'h44);

      // Random traffic on a few registers to force collisions.
      for (int n = 0; n < 500; n++) begin
         logic [4:0] cr;
         cr = 5'($urandom_range(0, 7));
         drive($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 4'($urandom), 1'($urandom_range(0, 1)), cr, $urandom,
               $urandom_range(0, 1) ? m_tag[cr] : 4'($urandom),
               5'($urandom_range(0, 7)), 5'($urandom));
         #1;
         model_read(bus.rs1_idx, b, t, v);
         chk("rnd rs1_busy", 32'(bus.rs1_busy), 32'(b));
         chk("rnd rs1_tag", 32'(bus.rs1_tag), 32'(t));
         chk("rnd rs1_val", bus.rs1_val, v);
         model_read(bus.rs2_idx, b, t, v);
         chk("rnd rs2_busy", 32'(bus.rs2_busy), 32'(b));
         chk("rnd rs2_tag", 32'(bus.rs2_tag), 32'(t));
         chk("rnd rs2_val", bus.rs2_val, v);
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
Architectural register file with per-register rename status (busy bit and ROB tag). It sits downstream of the reorder buffer and consumes its commit and flush outputs. It also sits beside issue: it renames rd on every issued instruction and answers rs1/rs2 operand queries with either a value or a ROB tag. On a misprediction flush it drops every rename so that all subsequent reads come from architectural state.

Parameters:
TAG_W, 4, width of a ROB index (ROB holds 2^TAG_W entries)
NREG, 32, number of architectural registers (x0 hard-wired to zero)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
rdy  input  1  global ready; when low, no state changes
flush  input  1  ROB misprediction flag (pred_fail_flag), registered in ROB
issue_valid  input  1  instruction issued this cycle
issue_rd  input  5  destination register of issued instruction (0 = none)
issue_robid  input  TAG_W  ROB slot allocated to issued instruction
commit_enable  input  1  ROB commits a register-writing instruction
commit_regid  input  5  committed destination register
commit_value  input  32  committed result
commit_robid  input  TAG_W  ROB slot being committed
rs1_idx  input  5  source-1 register index
rs2_idx  input  5  source-2 register index
rs1_busy  output  1  source 1 awaits ROB result
rs1_tag  output  TAG_W  ROB slot producing source 1 (valid when busy)
rs1_val  output  32  architectural value of source 1
rs2_busy  output  1  same for source 2
rs2_tag  output  TAG_W  same for source 2
rs2_val  output  32  same for source 2

Behaviour:
- State per register: val[31:0], busy, tag[TAG_W-1:0]. Reset clears all val, busy and tag to 0. Reset is synchronous and overrides rdy.
- rdy low: every register holds its state. Read ports stay combinational.
- Commit, on a clock edge with rdy=1, commit_enable=1 and commit_regid!=0:
  - val[commit_regid] <= commit_value.
  - busy[commit_regid] <= 0 only if busy was 1 and tag==commit_robid, so an older commit cannot clear a younger rename.
- Rename, on a clock edge with rdy=1, issue_valid=1, issue_rd!=0 and flush=0:
  - busy[issue_rd] <= 1 and tag[issue_rd] <= issue_robid.
- Same-cycle commit and rename of the same register: the rename wins (busy=1, new tag). The value is still written.
- Flush, on a clock edge with rdy=1 and flush=1:
  - All busy bits clear.
  - A commit in the same cycle still writes its value.
  - Issue in the same cycle is ignored, because ROB squashes it.
- x0: never busy, always reads 0. Writes and renames to x0 are discarded.
- Reads are combinational, with zero latency:
  - rsN_val = val[idx]; rsN_busy = busy[idx]; rsN_tag = tag[idx].
  - Reads return pre-edge state: a rename issued in the same cycle is not visible. Issue handles rs==rd of its own instruction because it queries sources before the rename.
- No arithmetic beyond index decode. Tags are opaque, with no wrap logic.

Optional Feature:
Macro REG_COMMIT_BYPASS_EN.
- Defined: for each read port, if commit_enable=1, commit_regid==idx!=0, busy[idx]=1 and tag[idx]==commit_robid, then:
  - rsN_busy=0 and rsN_val=commit_value in the same cycle.
  - This saves issue one cycle of waiting.
- Undefined: reads reflect register state only. The committed value becomes visible on the cycle after the commit edge. Issue obtains it meanwhile from the ROB value query.

Decomposition:
- Shared package (utils header): ROB_SIZE_LOG (drives TAG_W), REG_NUM=32, REG_ZERO=0 constants.
- One natural sub-module, reg_read_port: a combinational single-port mux including the optional bypass. It is instantiated twice, for rs1 and rs2.
- The state array and update logic stay in the top module.

Test Plan:
1. Reset, then read x5 -> busy=0, tag=0, val=0. Commit x5=0xDEADBEEF tag 3 with no rename -> next cycle val=0xDEADBEEF, busy=0.
2. Issue rd=7 robid=2; next cycle read x7 -> busy=1, tag=2. Commit x7 robid=2 value 0x11 -> next cycle busy=0, val=0x11.
3. Issue rd=7 robid=2, then issue rd=7 robid=5, then commit x7 robid=2 value 0x22 -> val=0x22, busy=1, tag=5 (an older commit does not clear).
4. Same cycle: commit x9 robid=4 (tag 4, busy) and issue rd=9 robid=6 -> val updated, busy=1, tag=6.
5. Rename x3/x8/x12, then flush with a commit of x3 value 0x33 and issue rd=10 in the same cycle -> all busy=0, x3=0x33, x10 not busy. With rdy=0 for any of these cycles -> no change.
6. Write/issue to x0 -> x0 reads 0, never busy. With REG_COMMIT_BYPASS_EN, a read of x7 (busy, tag 2) during a commit of robid 2 value 0x44 -> busy=0, val=0x44 in the same cycle. Without the macro -> busy=1 that cycle.
